// File: rtl/pu_msp430_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pu_msp430_sync_pkg
// Description : Shared types and constants for the toggle-handshake receiver.
// Revision    : 1.0  initial release
// ============================================================================
package pu_msp430_sync_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VALID = 1'b1
    } sync_rx_state_t;

    localparam int SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/pu_msp430_sync_stage.sv
`default_nettype none
// ============================================================================
// Module      : pu_msp430_sync_stage
// Description : Single-bit multi-flop synchronizer with synchronous reset.
// Revision    : 1.0  initial release
// ============================================================================
module pu_msp430_sync_stage
    import pu_msp430_sync_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Bit 0 is the metastability-catching flop; the MSB is the safe output.
    generate
        if (STAGES == 1) begin : g_single
            always_comb sync_d = d;
        end else begin : g_chain
            always_comb sync_d = {sync_q[STAGES-2:0], d};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pu_msp430_sync_bus_rx.sv
`default_nettype none
// ============================================================================
// Module      : pu_msp430_sync_bus_rx
// Description : Toggle-handshake bus receiver; captures a word per request
//               toggle, hands it out via valid/ready, returns an ack toggle.
//               Overrun detection is built only with PU_MSP430_SYNC_OVERRUN_EN.
// Revision    : 1.0  initial release
// ============================================================================
module pu_msp430_sync_bus_rx
    import pu_msp430_sync_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_toggle,
    input  logic [DW-1:0]    data_in,
    output logic [DW-1:0]    data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             ack_toggle,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             overrun,
    input  logic             overrun_clr
);

    sync_rx_state_t   state_q,    state_d;
    logic [DW-1:0]    data_q,     data_d;
    logic             ack_q,      ack_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             req_prev_q;
    logic             w_req_sync;
    logic             w_req_edge;

    pu_msp430_sync_stage #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_toggle),
        .q   (w_req_sync)
    );

    assign w_req_edge = w_req_sync ^ req_prev_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_req_edge) begin
                    data_d  = data_in;
                    state_d = VALID;
                end
            end
            VALID: begin
                // An edge arriving here is dropped; only ready moves us on.
                if (data_ready) begin
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            ack_q      <= 1'b0;
            cnt_q      <= '0;
            req_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            cnt_q      <= cnt_d;
            req_prev_q <= w_req_sync;
        end
    end

`ifdef PU_MSP430_SYNC_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Set has priority over a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if ((state_q == VALID) && w_req_edge) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    logic w_unused_overrun_clr;
    assign w_unused_overrun_clr = overrun_clr;
    assign overrun              = 1'b0;
`endif

    assign data_out   = data_q;
    assign data_valid = (state_q == VALID);
    assign ack_toggle = ack_q;
    assign xfer_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pu_msp430_sync_bus_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pu_msp430_sync_bus_rx
// Description : Directed self-checking bench for pu_msp430_sync_bus_rx.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pu_msp430_sync_bus_rx;

    localparam int DW    = 16;
    localparam int CNT_W = 8;
`ifdef PU_MSP430_SYNC_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req_toggle;
    logic [DW-1:0]    data_in;
    logic [DW-1:0]    data_out;
    logic             data_valid;
    logic             data_ready;
    logic             ack_toggle;
    logic [CNT_W-1:0] xfer_cnt;
    logic             overrun;
    logic             overrun_clr;

    int checks = 0;
    int errors = 0;

    pu_msp430_sync_bus_rx #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_toggle  (req_toggle),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .ack_toggle  (ack_toggle),
        .xfer_cnt    (xfer_cnt),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Behavioural model: a request toggle seen at edge n is acted upon at
    // edge n+2; the handshake itself is tracked as plain transaction state.
    logic          seen [3];
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_ack;
    int            m_cnt;
    bit            m_ovr;
    logic [DW-1:0] exp_q [$];

    always @(posedge clk) begin
        bit new_req;
        new_req = (seen[1] !== seen[2]);
        if (rst) begin
            seen[0] = 1'b0; seen[1] = 1'b0; seen[2] = 1'b0;
            m_valid = 0; m_data = '0; m_ack = 0; m_cnt = 0; m_ovr = 0;
        end else begin
            if (overrun_clr) m_ovr = 0;
            if (m_valid && new_req && OVR_EN) m_ovr = 1;
            if (m_valid) begin
                if (data_ready) begin
                    m_valid = 0;
                    m_ack   = !m_ack;
                    m_cnt   = (m_cnt + 1) % (1 << CNT_W);
                end
            end else if (new_req) begin
                m_valid = 1;
                m_data  = data_in;
            end
            seen[2] = seen[1];
            seen[1] = seen[0];
            seen[0] = req_toggle;
        end
    end

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process, plus an in-order scoreboard on every accepted word.
    always @(negedge clk) begin
        if (!rst) begin
            cmp("data_valid", data_valid, m_valid);
            cmp("data_out",   data_out,   m_data);
            cmp("ack_toggle", ack_toggle, m_ack);
            cmp("xfer_cnt",   xfer_cnt,   m_cnt);
            cmp("overrun",    overrun,    m_ovr);
            if (m_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    cmp("sb_empty", 1, 0);
                end else begin
                    cmp("sb_order", data_out, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w);
        data_in    = w;
        req_toggle = ~req_toggle;
        exp_q.push_back(w);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!data_valid && n < 20) begin
            tick();
            n++;
        end
        if (!data_valid) cmp("valid_timeout", 0, 1);
    endtask

    task automatic accept();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b1;
        req_toggle = 1'b0;
        exp_q.delete();
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_toggle = 1'b0; data_in = '0;
        data_ready = 1'b0; overrun_clr = 1'b0;
        tick();
        do_reset(3);
        tick();
        cmp("rst_valid", data_valid, 0);
        cmp("rst_data",  data_out,   0);
        cmp("rst_ack",   ack_toggle, 0);
        cmp("rst_cnt",   xfer_cnt,   0);

        // First word: valid appears on the second edge after the sampling edge
        send(16'hA5C3);
        tick(); tick();
        cmp("lat_early", data_valid, 0);
        tick();
        cmp("lat_valid", data_valid, 1);
        cmp("lat_data",  data_out,   16'hA5C3);
        cmp("lat_ack",   ack_toggle, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp("hold_valid", data_valid, 1);
        end
        accept();
        cmp("acc1_ack",   ack_toggle, 1);
        cmp("acc1_cnt",   xfer_cnt,   1);
        cmp("acc1_valid", data_valid, 0);

        // Data changes during VALID, then a protocol-violating toggle
        send(16'h1234);
        wait_valid();
        data_in = 16'hFFFF;
        tick();
        cmp("hold_data", data_out, 16'h1234);
        req_toggle = ~req_toggle;
        data_in    = 16'h5555;
        repeat (4) tick();
        cmp("ovr_data", data_out, 16'h1234);
        cmp("ovr_flag", overrun,  OVR_EN);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        cmp("ovr_clr", overrun, 0);
        accept();
        cmp("acc2_cnt", xfer_cnt,   2);
        cmp("acc2_ack", ack_toggle, 0);

        // Reset while VALID discards the word with no ack
        send(16'hBEEF);
        wait_valid();
        do_reset(1);
        cmp("mid_valid", data_valid, 0);
        cmp("mid_data",  data_out,   0);
        cmp("mid_ack",   ack_toggle, 0);
        cmp("mid_cnt",   xfer_cnt,   0);
        repeat (3) tick();
        cmp("mid_quiet", data_valid, 0);
        send(16'h0F0F);
        wait_valid();
        cmp("post_data", data_out, 16'h0F0F);
        accept();
        cmp("post_ack", ack_toggle, 1);

        // 256 transfers with random consumer delay: counter wraps, ack returns to 0
        do_reset(2);
        for (int i = 0; i < 256; i++) begin
            send(DW'(i * 3 + 1));
            wait_valid();
            repeat ($urandom_range(0, 3)) tick();
            accept();
        end
        tick();
        cmp("wrap_cnt",   xfer_cnt,     0);
        cmp("wrap_ack",   ack_toggle,   0);
        cmp("wrap_sb",    exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
